// File: rtl/mem_copy_pkg.sv
// mem_copy_pkg: shared widths and FSM state type for the block-copy engine.
package mem_copy_pkg;

   localparam int ADDR_W = 7;
   localparam int DATA_W = 32;
   localparam int LEN_W  = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/mem_copy_engine_if.sv
// mem_copy_engine_if: CPU control handshake plus the memory's dedicated
// read and write ports, as seen by the copy engine.
// master = the copy engine, slave = CPU control side and memory.
// Optional feature: MEM_COPY_CHECKSUM_EN adds the checksum signal.
interface mem_copy_engine_if;
   import mem_copy_pkg::*;

   logic              start;
   logic [ADDR_W-1:0] srcBase;
   logic [ADDR_W-1:0] dstBase;
   logic [LEN_W-1:0]  length;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] addressRead;
   logic [DATA_W-1:0] dataOutRead;
   logic [ADDR_W-1:0] addressWrite;
   logic [DATA_W-1:0] dataInWrite;
   logic              writeEnableWrite;
`ifdef MEM_COPY_CHECKSUM_EN
   logic [DATA_W-1:0] checksum;
`endif

   modport master (
      input  start, srcBase, dstBase, length, dataOutRead,
      output busy, done, addressRead, addressWrite, dataInWrite, writeEnableWrite
`ifdef MEM_COPY_CHECKSUM_EN
      , output checksum
`endif
   );

   modport slave (
      output start, srcBase, dstBase, length, dataOutRead,
      input  busy, done, addressRead, addressWrite, dataInWrite, writeEnableWrite
`ifdef MEM_COPY_CHECKSUM_EN
      , input checksum
`endif
   );

endinterface

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: copies a run of words between address ranges using the
// memory's dedicated read port (combinational) and write port, 1 word/cycle.
// Optional feature: MEM_COPY_CHECKSUM_EN keeps an XOR of all copied words.
//
// state | meaning
// IDLE  | waiting for start; no write pending
// RUN   | word at src_ptr being read, previously captured word being written
// DRAIN | last captured word being written; done pulses next cycle
module mem_copy_engine
   import mem_copy_pkg::*;
(
   input  logic               clk,
   input  logic               resetN,
   mem_copy_engine_if.master  bus
);

   state_t            state;
   logic [ADDR_W-1:0] src_ptr;
   logic [ADDR_W-1:0] dst_ptr;
   logic [LEN_W-1:0]  remaining;
   logic              busy_q;
   logic              done_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_w_q;
   logic [DATA_W-1:0] data_w_q;

   assign bus.addressRead      = src_ptr;
   assign bus.busy             = busy_q;
   assign bus.done             = done_q;
   assign bus.writeEnableWrite = we_q;
   assign bus.addressWrite     = addr_w_q;
   assign bus.dataInWrite      = data_w_q;

   // Copy sequencer: pointers, word counter and the one-deep write stage.
   // busy covers the N read cycles; the DRAIN write is already committed,
   // so busy drops there and the done cycle follows exactly N busy cycles.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state     <= IDLE;
         src_ptr   <= '0;
         dst_ptr   <= '0;
         remaining <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         we_q      <= 1'b0;
         addr_w_q  <= '0;
         data_w_q  <= '0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               we_q <= 1'b0;
               if (bus.start) begin
                  if (bus.length != '0) begin
                     src_ptr   <= bus.srcBase;
                     dst_ptr   <= bus.dstBase;
                     remaining <= bus.length;
                     busy_q    <= 1'b1;
                     state     <= RUN;
                  end else begin
                     done_q <= 1'b1;
                  end
               end
            end
            RUN: begin
               data_w_q  <= bus.dataOutRead;
               addr_w_q  <= dst_ptr;
               we_q      <= 1'b1;
               src_ptr   <= src_ptr + ADDR_W'(1);
               dst_ptr   <= dst_ptr + ADDR_W'(1);
               remaining <= remaining - LEN_W'(1);
               if (remaining == LEN_W'(1)) begin
                  busy_q <= 1'b0;
                  state  <= DRAIN;
               end
            end
            DRAIN: begin
               we_q   <= 1'b0;
               done_q <= 1'b1;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef MEM_COPY_CHECKSUM_EN
   logic [DATA_W-1:0] checksum_q;

   assign bus.checksum = checksum_q;

   // Running XOR of captured words; any start taken in IDLE clears it.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         checksum_q <= '0;
      end else if (state == IDLE && bus.start) begin
         checksum_q <= '0;
      end else if (state == RUN) begin
         checksum_q <= checksum_q ^ bus.dataOutRead;
      end
   end
`endif

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb_mem_copy_engine: bench for mem_copy_engine. Models the memory array,
// drives a table of copies (directed plus random) and compares timing and
// memory contents against a word-by-word reference of the copy rule.
// Optional feature: MEM_COPY_CHECKSUM_EN enables checksum checks.
module tb_mem_copy_engine;
   import mem_copy_pkg::*;

   typedef struct {
      logic [6:0]  src;
      logic [6:0]  dst;
      int          len;
      int          poke;
      logic [6:0]  pre_base;
      int          pre_n;
      logic [31:0] pre[4];
      int          want_n;
      logic [31:0] want[4];
      bit          csum_chk;
      logic [31:0] csum;
   } vec_t;

   localparam int NVEC = 11;

   logic clk = 1'b0;
   logic resetN;
   always #5 clk = ~clk;

   mem_copy_engine_if bus ();

   mem_copy_engine dut (
      .clk    (clk),
      .resetN (resetN),
      .bus    (bus)
   );

   logic [DATA_W-1:0] mem     [128];
   logic [DATA_W-1:0] ref_mem [128];
   logic [DATA_W-1:0] ref_xor;
   logic              pre_we;
   logic [6:0]        pre_addr;
   logic [31:0]       pre_data;
   vec_t              vecs [NVEC];
   int                checks = 0;
   int                failures = 0;

   assign bus.dataOutRead = mem[bus.addressRead];

   always @(posedge clk) begin
      if (pre_we) mem[pre_addr] <= pre_data;
      else if (bus.writeEnableWrite) mem[bus.addressWrite] <= bus.dataInWrite;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic vec_t mk(input logic [6:0] src, input logic [6:0] dst,
                               input int len, input int poke);
      vec_t v;
      v.src = src; v.dst = dst; v.len = len; v.poke = poke;
      v.pre_base = '0; v.pre_n = 0; v.want_n = 0; v.csum_chk = 1'b0; v.csum = '0;
      for (int i = 0; i < 4; i++) begin
         v.pre[i]  = '0;
         v.want[i] = '0;
      end
      return v;
   endfunction

   // preload words at base.. and expect them at the destination
   function automatic vec_t with_pre(input vec_t vin, input logic [6:0] base, input int n,
                                     input logic [31:0] d0, input logic [31:0] d1,
                                     input logic [31:0] d2, input logic [31:0] d3);
      vec_t v = vin;
      v.pre_base = base; v.pre_n = n; v.want_n = n;
      v.pre[0] = d0; v.pre[1] = d1; v.pre[2] = d2; v.pre[3] = d3;
      v.want = v.pre;
      return v;
   endfunction

   // called at a negedge; the write lands at the following posedge
   task automatic preload(input logic [6:0] a, input logic [31:0] d);
      pre_we = 1'b1; pre_addr = a; pre_data = d;
      @(negedge clk);
      pre_we = 1'b0;
   endtask

   // Reference: word i is read from memory that already holds words 0..i-2.
   task automatic model_copy(input logic [6:0] src, input logic [6:0] dst, input int len);
      logic [6:0]  pa;
      logic [31:0] pd;
      logic [31:0] w;
      bit          pend;
      pend = 1'b0; pa = '0; pd = '0;
      ref_mem = mem;
      ref_xor = '0;
      for (int i = 0; i < len; i++) begin
         w = ref_mem[src + 7'(i)];
         ref_xor ^= w;
         if (pend) ref_mem[pa] = pd;
         pa   = dst + 7'(i);
         pd   = w;
         pend = 1'b1;
      end
      if (pend) ref_mem[pa] = pd;
   endtask

   task automatic compare_mem(input string name);
      int bad;
      bad = -1;
      for (int i = 0; i < 128; i++)
         if (bad < 0 && mem[i] !== ref_mem[i]) bad = i;
      checks++;
      if (bad >= 0) begin
         failures++;
         $display("FAIL %s addr=%0d actual=%0h required=%0h", name, bad, mem[bad], ref_mem[bad]);
      end
   endtask

   // Runs one copy from a negedge; c counts negedges after the start edge E0.
   task automatic run_copy(input vec_t v);
      int          busy_cnt, we_cnt, done_cnt, done_c, c, exp_done;
      logic [31:0] cs_done;
      busy_cnt = 0; we_cnt = 0; done_cnt = 0; done_c = -1; cs_done = '0;
      exp_done = (v.len == 0) ? 0 : v.len + 1;
      model_copy(v.src, v.dst, v.len);
      bus.start = 1'b1; bus.srcBase = v.src; bus.dstBase = v.dst; bus.length = 8'(v.len);
      @(negedge clk);
      bus.start = 1'b0;
      bus.srcBase = 7'($urandom); bus.dstBase = 7'($urandom); bus.length = 8'($urandom);
      for (c = 0; c < v.len + 20; c++) begin
         if (bus.busy) busy_cnt++;
         if (bus.writeEnableWrite) we_cnt++;
         if (bus.done) begin
            done_cnt++;
            if (done_c < 0) begin
               done_c = c;
`ifdef MEM_COPY_CHECKSUM_EN
               cs_done = bus.checksum;
`endif
            end
         end
         if (done_c >= 0 && c >= done_c + 2) break;
         if (c == v.poke) begin
            bus.start = 1'b1;
            bus.srcBase = 7'($urandom); bus.dstBase = 7'($urandom);
            bus.length = 8'($urandom_range(1, 255));
         end else begin
            bus.start = 1'b0;
         end
         @(negedge clk);
      end
      bus.start = 1'b0;
      check($sformatf("done_latency len=%0d", v.len), 32'(done_c), 32'(exp_done));
      check($sformatf("done_pulses len=%0d", v.len), 32'(done_cnt), 32'd1);
      check($sformatf("busy_cycles len=%0d", v.len), 32'(busy_cnt), 32'(v.len));
      check($sformatf("write_cycles len=%0d", v.len), 32'(we_cnt), 32'(v.len));
      compare_mem($sformatf("mem_image src=%0d dst=%0d len=%0d", v.src, v.dst, v.len));
      for (int j = 0; j < v.want_n; j++)
         check($sformatf("dst_word %0d", v.dst + 7'(j)), mem[v.dst + 7'(j)], v.want[j]);
`ifdef MEM_COPY_CHECKSUM_EN
      if (v.len != 0) begin
         check($sformatf("checksum_done len=%0d", v.len), cs_done, ref_xor);
         check($sformatf("checksum_hold len=%0d", v.len), bus.checksum, ref_xor);
         if (v.csum_chk) check("checksum_const", cs_done, v.csum);
      end
`endif
   endtask

   // Reset asserted mid-copy: pending write dropped, earlier words kept, no done.
   task automatic reset_mid_copy();
      int rc, late;
      rc = 4; late = 0;
      model_copy(7'h00, 7'h70, rc - 1);
      bus.start = 1'b1; bus.srcBase = 7'h00; bus.dstBase = 7'h70; bus.length = 8'd10;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (rc) @(negedge clk);
      check("we_before_reset", 32'(bus.writeEnableWrite), 32'd1);
      #2 resetN = 1'b0;
      #1;
      check("rst_mid_we", 32'(bus.writeEnableWrite), 32'd0);
      check("rst_mid_busy", 32'(bus.busy), 32'd0);
      check("rst_mid_addr_w", 32'(bus.addressWrite), 32'd0);
      @(negedge clk);
      @(negedge clk);
      resetN = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (bus.done || bus.writeEnableWrite || bus.busy) late++;
         @(negedge clk);
      end
      check("rst_no_done_or_write", 32'(late), 32'd0);
      compare_mem("mem_after_reset");
   endtask

   initial begin
      resetN = 1'b0;
      bus.start = 1'b0; bus.srcBase = '0; bus.dstBase = '0; bus.length = '0;
      pre_we = 1'b0; pre_addr = '0; pre_data = '0;

      vecs[0]  = with_pre(mk(7'd0, 7'd16, 4, -1), 7'd0, 4, 32'd1, 32'd2, 32'd3, 32'd4);
      vecs[1]  = mk(7'd5, 7'd20, 0, -1);
      vecs[2]  = with_pre(mk(7'd126, 7'd40, 3, -1), 7'd126, 3, 32'hA, 32'hB, 32'hC, 32'h0);
      vecs[3]  = with_pre(mk(7'd10, 7'd11, 2, -1), 7'd10, 3, 32'd5, 32'd6, 32'd7, 32'd0);
      vecs[3].want_n = 2;
      vecs[4]  = mk(7'h30, 7'h50, 6, 2);
      vecs[5]  = with_pre(mk(7'h58, 7'h68, 3, -1), 7'h58, 3, 32'hF0, 32'h0F, 32'hFF, 32'h0);
      vecs[5].csum_chk = 1'b1; vecs[5].csum = 32'h0;
      vecs[6]  = with_pre(mk(7'h5C, 7'h6C, 2, -1), 7'h5C, 2, 32'h1, 32'h2, 32'h0, 32'h0);
      vecs[6].csum_chk = 1'b1; vecs[6].csum = 32'h3;
      vecs[7]  = mk(7'($urandom), 7'($urandom), 150, -1);
      for (int i = 8; i < NVEC; i++)
         vecs[i] = mk(7'($urandom), 7'($urandom), $urandom_range(1, 200), -1);

      #1;
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_we", 32'(bus.writeEnableWrite), 32'd0);
      check("rst_addr_r", 32'(bus.addressRead), 32'd0);
      check("rst_addr_w", 32'(bus.addressWrite), 32'd0);
      check("rst_data_w", bus.dataInWrite, 32'd0);
`ifdef MEM_COPY_CHECKSUM_EN
      check("rst_checksum", bus.checksum, 32'd0);
`endif
      @(negedge clk);
      @(negedge clk);
      resetN = 1'b1;

      for (int i = 0; i < 128; i++) preload(7'(i), $urandom);

      for (int v = 0; v < NVEC; v++) begin
         for (int j = 0; j < vecs[v].pre_n; j++)
            preload(vecs[v].pre_base + 7'(j), vecs[v].pre[j]);
         run_copy(vecs[v]);
      end

      reset_mid_copy();
      run_copy(mk(7'h05, 7'h45, 5, -1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
